// File: rtl/spatz_vcfg_unit_pkg.sv
// Types and helpers shared by the vector configuration unit.
package spatz_vcfg_unit_pkg;

    // Selected element width encoding; the upper half is reserved.
    typedef enum logic [2:0] {
        EW_8    = 3'b000,
        EW_16   = 3'b001,
        EW_32   = 3'b010,
        EW_64   = 3'b011,
        EW_RES4 = 3'b100,
        EW_RES5 = 3'b101,
        EW_RES6 = 3'b110,
        EW_RES7 = 3'b111
    } vew_e;

    // Register group multiplier encoding; 3'b100 is reserved.
    typedef enum logic [2:0] {
        LMUL_1   = 3'b000,
        LMUL_2   = 3'b001,
        LMUL_4   = 3'b010,
        LMUL_8   = 3'b011,
        LMUL_RES = 3'b100,
        LMUL_F8  = 3'b101,
        LMUL_F4  = 3'b110,
        LMUL_F2  = 3'b111
    } vlmul_e;

    typedef enum logic [1:0] {
        VSETVLI  = 2'd0,
        VSETIVLI = 2'd1,
        VSETVL   = 2'd2
    } vcfg_op_e;

    typedef struct packed {
        logic   vill;
        logic   vma;
        logic   vta;
        vew_e   vsew;
        vlmul_e vlmul;
    } vtype_t;

    localparam vtype_t VtypeIll = '{vill: 1'b1, vma: 1'b0, vta: 1'b0, vsew: EW_8, vlmul: LMUL_1};

    // VLMAX = (VLEN / SEW) * LMUL using shifts only.
    function automatic int unsigned vlmax(input int unsigned vlen, input vew_e vsew,
                                          input vlmul_e vlmul);
        logic [2:0]  sew_raw;
        logic [2:0]  lmul_raw;
        int unsigned elems;
        int unsigned res;
        sew_raw  = vsew;
        lmul_raw = vlmul;
        elems    = vlen >> (32'd3 + 32'(sew_raw));
        if (lmul_raw[2]) begin
            res = elems >> (32'd8 - 32'(lmul_raw));
        end else begin
            res = elems << lmul_raw[1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/spatz_vcfg_unit_vl_calc.sv
// Combinational vtype legality check, VLMAX and new-vl selection.
module spatz_vl_calc
    import spatz_vcfg_unit_pkg::*;
#(
    parameter int unsigned VLEN    = 512,
    parameter int unsigned ELEN    = 32,
    parameter int unsigned VlWidth = $clog2(VLEN) + 1
) (
    input  vcfg_op_e             op,
    input  logic [VlWidth-1:0]   avl,
    input  vtype_t               vtype,
    input  logic                 rs1_x0,
    input  logic                 rd_x0,
    input  vtype_t               old_vtype,
    input  logic [VlWidth-1:0]   old_vl,
    output vtype_t               new_vtype_c,
    output logic [VlWidth-1:0]   new_vl_c
);

    localparam logic [3:0] MaxSew = 4'($clog2(ELEN / 8));

    logic [2:0]         sew_raw;
    logic [2:0]         lmul_raw;
    logic               frac;
    logic [3:0]         frac_shift;
    logic               ill;
    logic [VlWidth-1:0] vlmax_new;
    logic [VlWidth-1:0] vlmax_old;

    assign vlmax_new = VlWidth'(vlmax(VLEN, vtype.vsew, vtype.vlmul));
    assign vlmax_old = VlWidth'(vlmax(VLEN, old_vtype.vsew, old_vtype.vlmul));

    // Illegal if SEW exceeds ELEN, LMUL is reserved, or SEW > ELEN*LMUL for fractional LMUL.
    always_comb begin
        sew_raw    = vtype.vsew;
        lmul_raw   = vtype.vlmul;
        frac       = lmul_raw[2];
        frac_shift = frac ? (4'd8 - {1'b0, lmul_raw}) : 4'd0;
        ill        = ({1'b0, sew_raw} > MaxSew)
                  || (vtype.vlmul == LMUL_RES)
                  || (frac && (({1'b0, sew_raw} + frac_shift) > MaxSew));
    end

    // Equal VLMAX at fixed VLEN is equivalent to an unchanged SEW/LMUL ratio.
    always_comb begin
        new_vtype_c      = vtype;
        new_vtype_c.vill = 1'b0;
        new_vl_c         = '0;
        if (ill) begin
            new_vtype_c = VtypeIll;
        end else if ((op == VSETIVLI) || !rs1_x0) begin
            new_vl_c = (avl < vlmax_new) ? avl : vlmax_new;
        end else if (!rd_x0) begin
            new_vl_c = vlmax_new;
        end else if (old_vtype.vill || (vlmax_old != vlmax_new)) begin
            new_vtype_c = VtypeIll;
        end else begin
            new_vl_c = old_vl;
        end
    end

endmodule

// File: rtl/spatz_vcfg_unit.sv
// Vector configuration unit: executes vset{i}vl{i} and owns vtype, vl and vstart.
module spatz_vcfg_unit
    import spatz_vcfg_unit_pkg::*;
#(
    parameter int unsigned VLEN    = 512,
    parameter int unsigned ELEN    = 32,
    parameter int unsigned VlWidth = $clog2(VLEN) + 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  vcfg_op_e           req_op_i,
    input  logic [VlWidth-1:0] req_avl_i,
    input  vtype_t             req_vtype_i,
    input  logic               req_rs1_x0_i,
    input  logic               req_rd_x0_i,
    input  logic               vec_busy_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [VlWidth-1:0] rsp_vl_o,
    input  logic               vstart_we_i,
    input  logic [VlWidth-1:0] vstart_wdata_i,
    input  logic               vstart_clr_i,
    output vtype_t             vtype_o,
    output logic [VlWidth-1:0] vl_o,
    output logic [VlWidth-1:0] vstart_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RSP  = 1'b1
    } state_e;

    localparam logic [VlWidth-1:0] VstartMax = VlWidth'(VLEN - 1);

    state_e             state_q;
    logic               out_of_reset_q;
    vtype_t             vtype_q;
    logic [VlWidth-1:0] vl_q;
    logic [VlWidth-1:0] vstart_q;
    logic [VlWidth-1:0] rsp_vl_q;
    logic               rsp_valid_q;

    vtype_t             new_vtype;
    logic [VlWidth-1:0] new_vl;
    logic [VlWidth-1:0] vstart_sat;
    logic               accept;

    // Accept only in IDLE once out of reset and with no vector op in flight.
    assign req_ready_o = out_of_reset_q && (state_q == IDLE) && !vec_busy_i;
    assign accept      = req_valid_i && req_ready_o;
    assign vstart_sat  = (vstart_wdata_i > VstartMax) ? VstartMax : vstart_wdata_i;

    spatz_vl_calc #(
        .VLEN    (VLEN),
        .ELEN    (ELEN),
        .VlWidth (VlWidth)
    ) i_vl_calc (
        .op          (req_op_i),
        .avl         (req_avl_i),
        .vtype       (req_vtype_i),
        .rs1_x0      (req_rs1_x0_i),
        .rd_x0       (req_rd_x0_i),
        .old_vtype   (vtype_q),
        .old_vl      (vl_q),
        .new_vtype_c (new_vtype),
        .new_vl_c    (new_vl)
    );

    // Request/response FSM together with the architectural state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            out_of_reset_q <= 1'b0;
            vtype_q        <= VtypeIll;
            vl_q           <= '0;
            vstart_q       <= '0;
            rsp_vl_q       <= '0;
            rsp_valid_q    <= 1'b0;
        end else begin
            out_of_reset_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        vtype_q     <= new_vtype;
                        vl_q        <= new_vl;
                        rsp_vl_q    <= new_vl;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
            if (accept) begin
                vstart_q <= '0;
            end else if (vstart_we_i) begin
                vstart_q <= vstart_sat;
            end else if (vstart_clr_i) begin
                vstart_q <= '0;
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_vl_o    = rsp_vl_q;
    assign vtype_o     = vtype_q;
    assign vl_o        = vl_q;
    assign vstart_o    = vstart_q;

endmodule

// File: tb/tb_spatz_vcfg_unit.sv
// Self-checking bench for spatz_vcfg_unit (VLEN=512, ELEN=32).
module tb_spatz_vcfg_unit;
    import spatz_vcfg_unit_pkg::*;

    localparam int VLEN    = 512;
    localparam int ELEN    = 32;
    localparam int VlWidth = 10;

    logic               clk = 1'b0;
    logic               rst_ni = 1'b1;
    logic               req_valid_i = 1'b0;
    logic               req_ready_o;
    vcfg_op_e           req_op_i = VSETVLI;
    logic [VlWidth-1:0] req_avl_i = '0;
    vtype_t             req_vtype_i = VtypeIll;
    logic               req_rs1_x0_i = 1'b0;
    logic               req_rd_x0_i = 1'b0;
    logic               vec_busy_i = 1'b0;
    logic               rsp_valid_o;
    logic               rsp_ready_i = 1'b1;
    logic [VlWidth-1:0] rsp_vl_o;
    logic               vstart_we_i = 1'b0;
    logic [VlWidth-1:0] vstart_wdata_i = '0;
    logic               vstart_clr_i = 1'b0;
    vtype_t             vtype_o;
    logic [VlWidth-1:0] vl_o;
    logic [VlWidth-1:0] vstart_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference architectural state
    logic [8:0] m_vtype = 9'h100;
    int         m_vl    = 0;

    typedef struct {
        int         op;
        int         avl;
        logic [8:0] vt;
        logic       rs1x0;
        logic       rdx0;
        int         exp_vl;
        logic       exp_vill;
    } vec_t;

    vec_t vecs[16];

    spatz_vcfg_unit #(.VLEN(VLEN), .ELEN(ELEN), .VlWidth(VlWidth)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op_i),
        .req_avl_i      (req_avl_i),
        .req_vtype_i    (req_vtype_i),
        .req_rs1_x0_i   (req_rs1_x0_i),
        .req_rd_x0_i    (req_rd_x0_i),
        .vec_busy_i     (vec_busy_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_vl_o       (rsp_vl_o),
        .vstart_we_i    (vstart_we_i),
        .vstart_wdata_i (vstart_wdata_i),
        .vstart_clr_i   (vstart_clr_i),
        .vtype_o        (vtype_o),
        .vl_o           (vl_o),
        .vstart_o       (vstart_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [8:0] mk(input int sew_code, input int lmul_code);
        return {3'b000, 3'(sew_code), 3'(lmul_code)};
    endfunction

    // LMUL as the fraction num/den
    task automatic lmul_frac(input int lm, output int num, output int den);
        if (lm < 4) begin
            num = 1 << lm;
            den = 1;
        end else begin
            num = 1;
            den = 1 << (8 - lm);
        end
    endtask

    // Reference: apply one config request to the model state, return expected results
    task automatic model_step(input int op, input int avl, input logic [8:0] vt,
                              input logic rs1x0, input logic rdx0,
                              output int evl, output logic [8:0] evt);
        int   sew, num, den, vmax, osew, onum, oden;
        logic legal;
        logic ok;
        sew = 8 << int'(vt[5:3]);
        lmul_frac(int'(vt[2:0]), num, den);
        legal = (sew <= ELEN) && (vt[2:0] != 3'd4) && (sew * den <= ELEN);
        vmax  = (VLEN * num) / (sew * den);
        osew  = 8 << int'(m_vtype[5:3]);
        lmul_frac(int'(m_vtype[2:0]), onum, oden);
        ok  = legal;
        evl = 0;
        if (!legal) begin
            ok = 1'b0;
        end else if (op == 1 || !rs1x0) begin
            evl = (avl < vmax) ? avl : vmax;
        end else if (!rdx0) begin
            evl = vmax;
        end else if (m_vtype[8] || (sew * den * onum != osew * oden * num)) begin
            ok = 1'b0;
        end else begin
            evl = m_vl;
        end
        if (!ok) evl = 0;
        evt     = ok ? {1'b0, vt[7:0]} : 9'h100;
        m_vtype = evt;
        m_vl    = evl;
    endtask

    // Drive one request, wait for acceptance, sample the response one cycle later
    task automatic do_cfg(input int op, input int avl, input logic [8:0] vt,
                          input logic rs1x0, input logic rdx0, output logic [9:0] rvl);
        int n;
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_op_i     = vcfg_op_e'(2'(op));
        req_avl_i    = 10'(avl);
        req_vtype_i  = vtype_t'(vt);
        req_rs1_x0_i = rs1x0;
        req_rd_x0_i  = rdx0;
        rsp_ready_i  = 1'b1;
        n = 0;
        while (!req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) check("accept_timeout", 32'(req_ready_o), 32'd1);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        check("rsp_latency", 32'(rsp_valid_o), 32'd1);
        rvl = rsp_vl_o;
    endtask

    task automatic run_cfg(input int op, input int avl, input logic [8:0] vt,
                           input logic rs1x0, input logic rdx0,
                           output logic [9:0] rvl, output logic vill);
        int         evl;
        logic [8:0] evt;
        logic [8:0] vt_act;
        model_step(op, avl, vt, rs1x0, rdx0, evl, evt);
        do_cfg(op, avl, vt, rs1x0, rdx0, rvl);
        vt_act = vtype_o;
        vill   = vt_act[8];
        check("rsp_vl", 32'(rvl), 32'(evl));
        check("vl", 32'(vl_o), 32'(evl));
        check("vtype", 32'(vt_act), 32'(evt));
        check("vstart_after_cfg", 32'(vstart_o), 32'd0);
    endtask

    task automatic vstart_write(input int data, input logic clr);
        @(negedge clk);
        vstart_we_i    = 1'b1;
        vstart_wdata_i = 10'(data);
        vstart_clr_i   = clr;
        @(negedge clk);
        vstart_we_i    = 1'b0;
        vstart_clr_i   = 1'b0;
    endtask

    initial begin
        logic [9:0] rvl;
        logic       vill;
        logic [9:0] held;
        logic [8:0] vt_act;
        int         evl;
        logic [8:0] evt;

        // op, avl, vtype, rs1x0, rdx0, expected vl, expected vill
        vecs[0]  = '{0, 20,   mk(2, 0), 1'b0, 1'b0, 16,  1'b0};
        vecs[1]  = '{1, 5,    mk(0, 7), 1'b0, 1'b0, 5,   1'b0};
        vecs[2]  = '{0, 0,    mk(0, 7), 1'b1, 1'b0, 32,  1'b0};
        vecs[3]  = '{0, 10,   mk(2, 5), 1'b0, 1'b0, 0,   1'b1};
        vecs[4]  = '{0, 10,   mk(3, 0), 1'b0, 1'b0, 0,   1'b1};
        vecs[5]  = '{2, 100,  mk(2, 0), 1'b0, 1'b0, 16,  1'b0};
        vecs[6]  = '{0, 0,    mk(1, 7), 1'b1, 1'b1, 16,  1'b0};
        vecs[7]  = '{0, 0,    mk(1, 1), 1'b1, 1'b1, 0,   1'b1};
        vecs[8]  = '{0, 0,    mk(2, 0), 1'b1, 1'b1, 0,   1'b1};
        vecs[9]  = '{2, 3,    mk(0, 4), 1'b0, 1'b0, 0,   1'b1};
        vecs[10] = '{0, 0,    mk(0, 3), 1'b1, 1'b0, 512, 1'b0};
        vecs[11] = '{0, 4,    mk(5, 0), 1'b0, 1'b0, 0,   1'b1};
        vecs[12] = '{1, 0,    mk(0, 0), 1'b0, 1'b0, 0,   1'b0};
        vecs[13] = '{0, 1023, mk(0, 3), 1'b0, 1'b0, 512, 1'b0};
        vecs[14] = '{1, 31,   mk(2, 6), 1'b0, 1'b0, 0,   1'b1};
        vecs[15] = '{0, 9,    mk(0, 6), 1'b0, 1'b0, 9,   1'b0};

        // Reset values
        #2 rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        vt_act = vtype_o;
        check("reset_ready", 32'(req_ready_o), 32'd0);
        check("reset_vtype", 32'(vt_act), 32'h100);
        check("reset_vl", 32'(vl_o), 32'd0);
        check("reset_vstart", 32'(vstart_o), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        rst_ni = 1'b1;

        // Directed table
        for (int i = 0; i < 16; i++) begin
            run_cfg(vecs[i].op, vecs[i].avl, vecs[i].vt, vecs[i].rs1x0, vecs[i].rdx0, rvl, vill);
            check($sformatf("tbl%0d_vl", i), 32'(rvl), 32'(vecs[i].exp_vl));
            check($sformatf("tbl%0d_vill", i), 32'(vill), 32'(vecs[i].exp_vill));
        end

        // vstart write, clear, saturation, priority
        vstart_write(7, 1'b0);
        check("vstart_we", 32'(vstart_o), 32'd7);
        @(negedge clk);
        vstart_clr_i = 1'b1;
        @(negedge clk);
        vstart_clr_i = 1'b0;
        check("vstart_clr", 32'(vstart_o), 32'd0);
        vstart_write(1000, 1'b0);
        check("vstart_sat", 32'(vstart_o), 32'd511);
        vstart_write(9, 1'b1);
        check("vstart_we_over_clr", 32'(vstart_o), 32'd9);

        // Config accept in the same cycle as a vstart write wins
        model_step(0, 20, mk(2, 0), 1'b0, 1'b0, evl, evt);
        @(negedge clk);
        req_valid_i    = 1'b1;
        req_op_i       = VSETVLI;
        req_avl_i      = 10'd20;
        req_vtype_i    = vtype_t'(mk(2, 0));
        req_rs1_x0_i   = 1'b0;
        req_rd_x0_i    = 1'b0;
        vstart_we_i    = 1'b1;
        vstart_wdata_i = 10'd7;
        #1 check("cfg_we_ready", 32'(req_ready_o), 32'd1);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        vstart_we_i = 1'b0;
        @(negedge clk);
        check("cfg_over_we_vstart", 32'(vstart_o), 32'd0);
        check("cfg_over_we_vl", 32'(rsp_vl_o), 32'(evl));

        // Busy holds off the request; response held while not accepted
        model_step(0, 40, mk(0, 0), 1'b0, 1'b0, evl, evt);
        @(negedge clk);
        vec_busy_i   = 1'b1;
        req_valid_i  = 1'b1;
        req_op_i     = VSETVLI;
        req_avl_i    = 10'd40;
        req_vtype_i  = vtype_t'(mk(0, 0));
        req_rs1_x0_i = 1'b0;
        req_rd_x0_i  = 1'b0;
        rsp_ready_i  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("busy_no_ready", 32'(req_ready_o), 32'd0);
        end
        check("busy_no_rsp", 32'(rsp_valid_o), 32'd0);
        vec_busy_i = 1'b0;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        check("busy_drop_rsp", 32'(rsp_valid_o), 32'd1);
        check("busy_drop_vl", 32'(rsp_vl_o), 32'(evl));
        held = rsp_vl_o;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid_o), 32'd1);
            check("stall_vl", 32'(rsp_vl_o), 32'(held));
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        check("stall_release", 32'(rsp_valid_o), 32'd0);

        // Reset while a response is pending
        rsp_ready_i = 1'b0;
        model_step(0, 5, mk(2, 0), 1'b0, 1'b0, evl, evt);
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_avl_i    = 10'd5;
        req_vtype_i  = vtype_t'(mk(2, 0));
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        check("pre_reset_rsp", 32'(rsp_valid_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        vt_act = vtype_o;
        check("midrsp_reset_valid", 32'(rsp_valid_o), 32'd0);
        check("midrsp_reset_vl", 32'(vl_o), 32'd0);
        check("midrsp_reset_vtype", 32'(vt_act), 32'h100);
        @(negedge clk);
        rst_ni      = 1'b1;
        rsp_ready_i = 1'b1;
        m_vtype     = 9'h100;
        m_vl        = 0;
        @(negedge clk);
        check("post_reset_rsp", 32'(rsp_valid_o), 32'd0);

        // Randomized requests against the model
        for (int i = 0; i < 300; i++) begin
            int         op, avl, sc, lm, d;
            logic [8:0] vt;
            op  = int'($urandom_range(0, 2));
            avl = (op == 1) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 1023));
            sc  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 2));
            lm  = int'($urandom_range(0, 7));
            vt  = {1'b0, 2'($urandom_range(0, 3)), 3'(sc), 3'(lm)};
            run_cfg(op, avl, vt, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), rvl, vill);
            if ($urandom_range(0, 4) == 0) begin
                d = int'($urandom_range(0, 1023));
                vstart_write(d, 1'b0);
                check("rand_vstart", 32'(vstart_o), 32'((d > VLEN - 1) ? VLEN - 1 : d));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
